// File: rtl/compressor_stream.sv
// compressor_stream
//   Converts a stream of IEEE-754 single-precision values into signed
//   fixed-point fractions of OUT_W bits (sign + OUT_W-1 magnitude bits,
//   MSB weight 2^-1). It packs LANES = 32/OUT_W of them per 32-bit output
//   word. A word closes when its last lane fills or when an in_last
//   element is packed.
//
//   Pipeline: stage 1 registers the converted element. Stage 2 merges it
//   into the pack accumulator or moves the finished word to the output
//   register. Latency from acceptance of the completing element to
//   out_valid is 2 cycles.
//
//   Build option: define COMPRESSOR_ROUND_EN for round-half-up of the
//   magnitude. Otherwise the magnitude is truncated.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  input handshake
//   in_data[31:0]      FP32 element
//   in_last            final element of a frame
//   out_valid/out_ready output handshake
//   out_data[31:0]     packed word, lane k at [k*OUT_W +: OUT_W]
//   out_keep[LANES-1:0] filled-lane mask
//   out_last           word closed by in_last
//   sat_count          saturated-element counter (sticks at max)
//   clr_stats          synchronous clear of sat_count (wins over increment)
module compressor_stream #(
    parameter int OUT_W     = 8,
    parameter int SAT_CNT_W = 16,
    localparam int LANES    = 32 / OUT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [LANES-1:0]     out_keep,
    output logic                 out_last,
    output logic [SAT_CNT_W-1:0] sat_count,
    input  logic                 clr_stats
);

    localparam int MAG_W  = OUT_W - 1;
    localparam int LANE_W = $clog2(LANES);

    if (!(OUT_W == 4 || OUT_W == 8 || OUT_W == 16)) begin : g_bad_out_w
        $error("compressor_stream: OUT_W must be 4, 8 or 16");
    end

    // ---------------- conversion (combinational, from in_data) ----------
    logic [7:0]       exp_f;
    logic [7:0]       shift;
    logic [23:0]      shifted;
    logic [MAG_W-1:0] trunc_mag;
    logic [MAG_W-1:0] conv_mag;
    logic             conv_sat;
    logic [OUT_W-1:0] conv_elem;

    always_comb begin
        exp_f     = in_data[30:23];
        shift     = 8'd127 - exp_f;
        shifted   = {1'b1, in_data[22:0]} >> shift;
        // Bits [22 -: MAG_W]; bit 23 is dropped because |x| < 1 on this path.
        trunc_mag = MAG_W'(shifted >> (23 - MAG_W));
        conv_mag  = '0;
        conv_sat  = 1'b0;
        if (exp_f >= 8'd127) begin
            conv_mag = '1;
            conv_sat = 1'b1;
        end else if (exp_f == 8'd0 || shift >= 8'd24) begin
            conv_mag = '0;
        end else begin
`ifdef COMPRESSOR_ROUND_EN
            if (shifted[22-MAG_W]) begin
                if (&trunc_mag) begin
                    conv_mag = '1;
                    conv_sat = 1'b1;
                end else begin
                    conv_mag = trunc_mag + MAG_W'(1);
                end
            end else begin
                conv_mag = trunc_mag;
            end
`else
            conv_mag = trunc_mag;
`endif
        end
        // A zero magnitude never carries a sign.
        conv_elem = {(conv_mag != '0) & in_data[31], conv_mag};
    end

    // ---------------- handshake / flow control -----------------------------
    logic             s1_valid;
    logic [OUT_W-1:0] s1_elem;
    logic             s1_last;
    logic [LANE_W-1:0] lane_ptr;
    logic [31:0]      acc_data;
    logic [LANES-1:0] acc_keep;

    logic completes;
    logic out_free;
    logic s1_advance;
    logic accept;

    always_comb begin
        completes  = s1_last || (lane_ptr == LANE_W'(LANES - 1));
        out_free   = !out_valid || out_ready;
        // Stage 1 may merge freely. It only stalls when it would close a
        // word while the output register holds one that is not leaving.
        s1_advance = s1_valid && (!completes || out_free);
        in_ready   = !s1_valid || s1_advance;
        accept     = in_valid && in_ready;
    end

    // ---------------- stage 1 ----------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_elem  <= '0;
            s1_last  <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_elem  <= conv_elem;
            s1_last  <= in_last;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // ---------------- stage 2: pack accumulator ----------------------------
    logic [31:0]      merged_data;
    logic [LANES-1:0] merged_keep;

    always_comb begin
        merged_data = acc_data;
        merged_keep = acc_keep;
        for (int k = 0; k < LANES; k++) begin
            if (lane_ptr == LANE_W'(k)) begin
                merged_data[k*OUT_W +: OUT_W] = s1_elem;
                merged_keep[k]                = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_data <= '0;
            acc_keep <= '0;
            lane_ptr <= '0;
        end else if (s1_advance) begin
            if (completes) begin
                acc_data <= '0;
                acc_keep <= '0;
                lane_ptr <= '0;
            end else begin
                acc_data <= merged_data;
                acc_keep <= merged_keep;
                lane_ptr <= lane_ptr + LANE_W'(1);
            end
        end
    end

    // ---------------- output register ---------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (s1_advance && completes) begin
            out_valid <= 1'b1;
            out_data  <= merged_data;
            out_keep  <= merged_keep;
            out_last  <= s1_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // ---------------- saturation statistics ---------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (clr_stats) begin
            sat_count <= '0;
        end else if (accept && conv_sat && (sat_count != '1)) begin
            sat_count <= sat_count + SAT_CNT_W'(1);
        end
    end

endmodule
